// File: rtl/load_writeback_unit_pkg.sv
// Shared encodings for the load/writeback unit: register-file width codes,
// load funct3 codes, FSM state encoding and the alignment/legality check.
package load_writeback_unit_pkg;

    localparam logic [3:0] WIDTH_BYTE = 4'd1;
    localparam logic [3:0] WIDTH_HALF = 4'd2;
    localparam logic [3:0] WIDTH_WORD = 4'd4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    // Undefined funct3 is treated the same as a misaligned access.
    function automatic logic load_legal(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_LB, F3_LBU: load_legal = 1'b1;
            F3_LH, F3_LHU: load_legal = ~addr_lo[0];
            F3_LW:         load_legal = (addr_lo == 2'b00);
            default:       load_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_writeback_unit_extract.sv
// Combinational lane select and sign/zero extension of a loaded word.
module load_data_extract
    import load_writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic [1:0]            addr_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [3:0]            width_o
);

    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign byte_l = word_i[{addr_i, 3'b000} +: 8];
    assign half_l = word_i[{addr_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o  = word_i;
        width_o = WIDTH_WORD;
        case (funct3_i)
            F3_LB:  data_o = {{(DATA_WIDTH-8){byte_l[7]}}, byte_l};
            F3_LH:  data_o = {{(DATA_WIDTH-16){half_l[15]}}, half_l};
            F3_LBU: begin
                data_o  = {{(DATA_WIDTH-8){1'b0}}, byte_l};
                width_o = WIDTH_BYTE;
            end
            F3_LHU: begin
                data_o  = {{(DATA_WIDTH-16){1'b0}}, half_l};
                width_o = WIDTH_HALF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_writeback_unit.sv
// Single-outstanding load unit: issues an aligned word read, then writes the
// extracted lane back to the register file.
module load_writeback_unit
    import load_writeback_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [2:0]                req_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      mem_rd_valid,
    input  logic                      mem_rd_ready,
    output logic [31:0]               mem_rd_addr,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_data,
    output logic                      rf_write_enable,
    output logic [3:0]                rf_write_width,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      busy,
    output logic                      misaligned_fault
);

    logic [1:0]                state_q, state_d;
    logic                      fault_q, fault_d;
    logic [31:0]               addr_q;
    logic [2:0]                funct3_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      accept;

    // The cycle after a rejected request is still IDLE but must not accept.
    assign req_ready        = (state_q == ST_IDLE) && !fault_q && !reset;
    assign accept           = req_valid && req_ready;
    assign busy             = (state_q != ST_IDLE);
    assign misaligned_fault = fault_q;
    assign mem_rd_valid     = (state_q == ST_ISSUE);
    assign mem_rd_addr      = {addr_q[31:2], 2'b00};
    assign rf_write_enable  = (state_q == ST_WB) && (rd_q != '0);
    assign rf_write_addr    = rd_q;

    always_comb begin
        state_d = state_q;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (load_legal(req_funct3, req_addr[1:0])) state_d = ST_ISSUE;
                else                                       fault_d = 1'b1;
            end
            ST_ISSUE: if (mem_rd_ready)   state_d = ST_WAIT;
            ST_WAIT:  if (mem_resp_valid) state_d = ST_WB;
            ST_WB:                        state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                rd_q     <= req_rd;
            end
            if (state_q == ST_WAIT && mem_resp_valid) data_q <= mem_resp_data;
        end
    end

    load_data_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .word_i   (data_q),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (rf_write_data),
        .width_o  (rf_write_width)
    );

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: vector table of loads plus
// hand-written misaligned, stray-response and reset-abandon sequences.
module tb_load_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_rd_valid, mem_rd_ready;
    logic [31:0] mem_rd_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        rf_write_enable;
    logic [3:0]  rf_write_width;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        busy, misaligned_fault;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    load_writeback_unit #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_funct3(req_funct3), .req_rd(req_rd),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .rf_write_enable(rf_write_enable), .rf_write_width(rf_write_width),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .busy(busy), .misaligned_fault(misaligned_fault)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] resp;
        int          rdy_wait;
        logic        exp_we;
        logic [3:0]  ew;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is #1 after a posedge with the DUT idle.
    task automatic do_load(input vec_t v);
        int nwr;
        chk({v.name, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = v.addr; req_funct3 = v.f3; req_rd = v.rd;
        step();
        req_valid = 1'b0; req_addr = 32'hx;
        chk({v.name, " issue valid"}, 32'(mem_rd_valid), 32'd1);
        chk({v.name, " issue addr"}, mem_rd_addr, {v.addr[31:2], 2'b00});
        chk({v.name, " busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < v.rdy_wait; k++) begin
            step();
            chk({v.name, " held valid"}, 32'(mem_rd_valid), 32'd1);
            chk({v.name, " held addr"}, mem_rd_addr, {v.addr[31:2], 2'b00});
        end
        mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        chk({v.name, " wait no valid"}, 32'(mem_rd_valid), 32'd0);
        chk({v.name, " wait no we"}, 32'(rf_write_enable), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = v.resp;
        step();
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        chk({v.name, " wb we"}, 32'(rf_write_enable), 32'(v.exp_we));
        nwr = 0;
        for (int j = 0; j < 4; j++) begin
            if (rf_write_enable === 1'b1) begin
                nwr++;
                chk({v.name, " width"}, 32'(rf_write_width), 32'(v.ew));
                chk({v.name, " data"}, rf_write_data, v.ed);
                chk({v.name, " rd"}, 32'(rf_write_addr), 32'(v.rd));
            end
            step();
        end
        chk({v.name, " write count"}, nwr, 32'(v.exp_we));
        chk({v.name, " idle after"}, 32'(busy), 32'd0);
    endtask

    task automatic do_bad(input string nm, input logic [31:0] a, input logic [2:0] f3);
        int nwr;
        req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rd = 5'd9;
        step();
        req_valid = 1'b0;
        chk({nm, " fault"}, 32'(misaligned_fault), 32'd1);
        chk({nm, " ready low"}, 32'(req_ready), 32'd0);
        chk({nm, " no busy"}, 32'(busy), 32'd0);
        nwr = 0;
        for (int j = 0; j < 3; j++) begin
            if (mem_rd_valid !== 1'b0) nwr++;
            if (rf_write_enable !== 1'b0) nwr++;
            step();
            if (j == 0) chk({nm, " fault pulse"}, 32'(misaligned_fault), 32'd0);
        end
        chk({nm, " no mem/wr"}, nwr, 32'd0);
        chk({nm, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        vecs[0] = '{"LBU103", 32'h103, 3'b100, 5'd5,  32'h80AB12CD, 0, 1'b1, 4'd1, 32'h00000080};
        vecs[1] = '{"LH102",  32'h102, 3'b001, 5'd6,  32'h9ABC0000, 0, 1'b1, 4'd4, 32'hFFFF9ABC};
        vecs[2] = '{"LHU102", 32'h102, 3'b101, 5'd6,  32'h9ABC0000, 0, 1'b1, 4'd2, 32'h00009ABC};
        vecs[3] = '{"LB101",  32'h101, 3'b000, 5'd1,  32'h80AB12CD, 1, 1'b1, 4'd4, 32'h00000012};
        vecs[4] = '{"LB102",  32'h102, 3'b000, 5'd31, 32'h80AB12CD, 0, 1'b1, 4'd4, 32'hFFFFFFAB};
        vecs[5] = '{"LH100",  32'h100, 3'b001, 5'd2,  32'h9ABC8001, 0, 1'b1, 4'd4, 32'hFFFF8001};
        vecs[6] = '{"LW200",  32'h200, 3'b010, 5'd7,  32'h12345678, 3, 1'b1, 4'd4, 32'h12345678};
        vecs[7] = '{"LWrd0",  32'h204, 3'b010, 5'd0,  32'hFFFFFFFF, 0, 1'b0, 4'd4, 32'hFFFFFFFF};
        vecs[8] = '{"LBU100", 32'h100, 3'b100, 5'd3,  32'h000000FE, 0, 1'b1, 4'd1, 32'h000000FE};

        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
        mem_rd_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        step(); step();
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst mem_valid", 32'(mem_rd_valid), 32'd0);
        chk("rst we", 32'(rf_write_enable), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fault", 32'(misaligned_fault), 32'd0);
        chk("rst rd field", 32'(rf_write_addr), 32'd0);
        chk("rst addr field", mem_rd_addr, 32'd0);
        reset = 1'b0;
        #1;
        chk("post-rst ready", 32'(req_ready), 32'd1);
        step();

        foreach (vecs[i]) do_load(vecs[i]);

        do_bad("LW202", 32'h202, 3'b010);
        do_bad("LH101", 32'h101, 3'b001);
        do_bad("F3_011", 32'h100, 3'b011);
        do_load(vecs[0]);

        // Stray response while idle must be ignored.
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
        step();
        mem_resp_valid = 1'b0;
        chk("stray busy", 32'(busy), 32'd0);
        chk("stray we", 32'(rf_write_enable), 32'd0);
        step();
        chk("stray we2", 32'(rf_write_enable), 32'd0);

        // Reset while waiting for the response abandons the load.
        req_valid = 1'b1; req_addr = 32'h300; req_funct3 = 3'b010; req_rd = 5'd4;
        step();
        req_valid = 1'b0; mem_rd_ready = 1'b1;
        step();
        mem_rd_ready = 1'b0;
        chk("abandon in wait busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abandon busy", 32'(busy), 32'd0);
        chk("abandon we", 32'(rf_write_enable), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        step();
        mem_resp_valid = 1'b0;
        nwr = 0;
        for (int j = 0; j < 3; j++) begin
            if (rf_write_enable !== 1'b0) nwr++;
            if (busy !== 1'b0) nwr++;
            step();
        end
        chk("abandon no write", nwr, 32'd0);
        chk("abandon ready", 32'(req_ready), 32'd1);
        do_load(vecs[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
